// File: rtl/nv_tx_pkg.sv
// Shared encodings for the NV transmit serializer: status codes, FSM states and the
// preamble pattern driven on every lane before the first data beat.
package nv_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] STATUS_IDLE = 2'd0;
  localparam logic [1:0] STATUS_BUSY = 2'd1;
  localparam logic [1:0] STATUS_DONE = 2'd2;
  localparam logic [1:0] STATUS_ERR  = 2'd3;

  localparam logic PREAMBLE_BIT = 1'b1;

  function automatic logic [1:0] state_to_status(state_e s);
    logic [1:0] st;
    unique case (s)
      StPre, StShift: st = STATUS_BUSY;
      StDone:         st = STATUS_DONE;
      StErr:          st = STATUS_ERR;
      default:        st = STATUS_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/nv_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the serializer; rdata_o always shows
// the oldest word so the serializer can load it in the same cycle it pops.
module nv_tx_fifo
  import nv_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on the registered level, so a write while full is dropped even
  // when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nv_tx_serializer.sv
// Buffers parallel words and sends them as framed bursts (preamble, then frame_len words)
// over LANES serial lanes toward the NV pads, reporting busy/done/underflow status.
module nv_tx_serializer
  import nv_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LANES        = 1,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PREAMBLE_CYC = 4,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic                    clkp,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  fifo_level,
  input  logic                    start,
  input  logic [$clog2(DEPTH):0]  frame_len,
  output logic [1:0]              status,
  output logic [LANES-1:0]        data_out,
  output logic                    data_valid
);

  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int unsigned BEATS = DATA_W / LANES;
  localparam int unsigned BW    = $clog2(BEATS + 1);
  localparam int unsigned PW    = $clog2(PREAMBLE_CYC + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [LW-1:0]     word_cnt_q, word_cnt_d;
  logic [LW-1:0]     frame_len_q, frame_len_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [LANES-1:0]  data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  logic              fifo_pop, fifo_flush, fifo_empty, load_word;
  logic [DATA_W-1:0] fifo_rdata;

  function automatic logic [LANES-1:0] head(logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w[DATA_W-1 -: LANES];
    else                return w[LANES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w << LANES;
    else                return w >> LANES;
  endfunction

  nv_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clkp),
    .rst_i   (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    word_cnt_d   = word_cnt_q;
    frame_len_d  = frame_len_q;
    sreg_d       = sreg_q;
    data_out_d   = '0;
    data_valid_d = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    load_word    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start && frame_len != '0) begin
          state_d     = StPre;
          frame_len_d = frame_len;
          pre_cnt_d   = '0;
          data_out_d  = {LANES{PREAMBLE_BIT}};
        end
      end
      StPre: begin
        data_out_d = {LANES{PREAMBLE_BIT}};
        if (pre_cnt_q == PW'(PREAMBLE_CYC - 1)) begin
          load_word  = 1'b1;
          word_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (beat_cnt_q == BW'(BEATS - 1)) begin
          if (word_cnt_q == frame_len_q - 1'b1) begin
            state_d = StDone;
          end else begin
            load_word  = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else begin
          beat_cnt_d   = beat_cnt_q + 1'b1;
          data_out_d   = head(sreg_q);
          sreg_d       = advance(sreg_q);
          data_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Word boundary: the popped word's first beat is registered on this same edge,
    // which keeps consecutive words gapless.
    if (load_word) begin
      if (fifo_empty) begin
        state_d    = StErr;
        fifo_flush = 1'b1;
        data_out_d = '0;
      end else begin
        state_d      = StShift;
        fifo_pop     = 1'b1;
        beat_cnt_d   = '0;
        data_out_d   = head(fifo_rdata);
        sreg_d       = advance(fifo_rdata);
        data_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pre_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      word_cnt_q   <= '0;
      frame_len_q  <= '0;
      sreg_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      word_cnt_q   <= word_cnt_d;
      frame_len_q  <= frame_len_d;
      sreg_q       <= sreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign status     = state_to_status(state_q);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_nv_tx_serializer.sv
// Self-checking bench: random words pushed into a queue model, each frame's expected
// serial stream derived from the framing rules (preamble, beat slices, done/underflow).
module tb_nv_tx_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int P     = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clkp  = 1'b0;
  logic          reset = 1'b1;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic [LW-1:0] fifo_level;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [1:0]    status;
  logic [0:0]    data_out;
  logic          data_valid;

  logic          b_wr_en = 1'b0;
  logic [DW-1:0] b_wr_data = '0;
  logic          b_full;
  logic [LW-1:0] b_fifo_level;
  logic          b_start = 1'b0;
  logic [LW-1:0] b_frame_len = '0;
  logic [1:0]    b_status;
  logic [3:0]    b_data_out;
  logic          b_data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model_q[$];

  always #5 clkp = ~clkp;

  nv_tx_serializer dut (
    .clkp       (clkp),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .fifo_level (fifo_level),
    .start      (start),
    .frame_len  (frame_len),
    .status     (status),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  nv_tx_serializer #(
    .DATA_W       (DW),
    .LANES        (4),
    .DEPTH        (DEPTH),
    .PREAMBLE_CYC (P),
    .MSB_FIRST    (0)
  ) dut_w4 (
    .clkp       (clkp),
    .reset      (reset),
    .wr_en      (b_wr_en),
    .wr_data    (b_wr_data),
    .full       (b_full),
    .fifo_level (b_fifo_level),
    .start      (b_start),
    .frame_len  (b_frame_len),
    .status     (b_status),
    .data_out   (b_data_out),
    .data_valid (b_data_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clkp);
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(w);
  endtask

  // Drives one frame from a negedge and checks every cycle until done or underflow.
  task automatic run_frame(input int n, input bit hold);
    logic [DW-1:0] w;
    start     = 1'b1;
    frame_len = LW'(n);
    @(negedge clkp);
    if (hold) frame_len = LW'(1);
    else      start = 1'b0;
    for (int c = 0; c < P; c++) begin
      check_eq("preamble", {status, data_valid, data_out}, {2'd1, 1'b0, 1'b1});
      @(negedge clkp);
    end
    for (int i = 0; i < n; i++) begin
      if (model_q.size() == 0) begin
        start = 1'b0;
        check_eq("underflow", {status, data_valid, data_out}, {2'd3, 1'b0, 1'b0});
        check_eq("uf_level", 32'(fifo_level), 32'd0);
        return;
      end
      w = model_q.pop_front();
      for (int k = 0; k < DW; k++) begin
        if (i == n - 1 && k == DW - 1) start = 1'b0;
        check_eq("beat", {status, data_valid, data_out},
                 {2'd1, 1'b1, 1'((w >> (DW - 1 - k)) & 8'd1)});
        @(negedge clkp);
      end
    end
    check_eq("done", {status, data_valid, data_out}, {2'd2, 1'b0, 1'b0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bw;
    int nw;
    int nf;

    // Reset state
    repeat (2) @(negedge clkp);
    check_eq("rst_out", {status, data_valid, data_out, full}, 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    reset = 1'b0;
    @(negedge clkp);

    // Two-word frame, MSB first on one lane
    push(8'hA5);
    push(8'h3C);
    check_eq("level2", 32'(fifo_level), 32'd2);
    run_frame(2, 1'b0);

    // Four lanes, LSB first
    bw          = 8'h5A;
    b_wr_en     = 1'b1;
    b_wr_data   = bw;
    @(negedge clkp);
    b_wr_en     = 1'b0;
    b_start     = 1'b1;
    b_frame_len = LW'(1);
    @(negedge clkp);
    b_start = 1'b0;
    for (int c = 0; c < P + 3; c++) begin
      if (c < P)
        check_eq("w4_pre", {b_status, b_data_valid, b_data_out}, {2'd1, 1'b0, 4'hF});
      else if (c < P + 2)
        check_eq("w4_beat", {b_status, b_data_valid, b_data_out},
                 {2'd1, 1'b1, 4'((bw >> (4 * (c - P))) & 8'h0F)});
      else
        check_eq("w4_done", {b_status, b_data_valid, b_data_out}, {2'd2, 1'b0, 4'h0});
      @(negedge clkp);
    end

    // Underflow on the second word boundary
    push(8'($urandom));
    run_frame(3, 1'b0);
    @(negedge clkp);
    check_eq("err_hold", {status, data_valid, data_out}, {2'd3, 1'b0, 1'b0});

    // Overflow: extra words dropped, first DEPTH words sent in order
    for (int i = 0; i < DEPTH + 2; i++) push(8'($urandom));
    check_eq("full", 32'(full), 32'd1);
    check_eq("level_full", 32'(fifo_level), 32'(DEPTH));
    run_frame(DEPTH, 1'b0);

    // start held through the frame, mid-frame refill, then a zero-length start
    push(8'($urandom));
    push(8'($urandom));
    fork
      run_frame(4, 1'b1);
      begin
        repeat (P + 10) @(negedge clkp);
        push(8'($urandom));
        push(8'($urandom));
      end
    join
    start     = 1'b1;
    frame_len = '0;
    @(negedge clkp);
    start = 1'b0;
    check_eq("len0_ignored", {status, data_valid, data_out}, {2'd2, 1'b0, 1'b0});

    // Random frames, occasionally under-filled
    for (int r = 0; r < 6; r++) begin
      nw = int'($urandom_range(0, 4));
      for (int i = 0; i < nw; i++) push(8'($urandom));
      check_eq("rand_level", 32'(fifo_level), 32'(model_q.size()));
      nf = int'($urandom_range(1, model_q.size() + 1));
      run_frame(nf, 1'b0);
      @(negedge clkp);
    end

    // Reset in the middle of SHIFT
    for (int i = 0; i < 3; i++) push(8'($urandom));
    start     = 1'b1;
    frame_len = LW'(3);
    @(negedge clkp);
    start = 1'b0;
    repeat (P + 3) @(negedge clkp);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_out", {status, data_valid, data_out, full}, 32'd0);
    check_eq("midrst_level", 32'(fifo_level), 32'd0);
    @(negedge clkp);
    reset = 1'b0;
    model_q.delete();
    @(negedge clkp);
    push(8'($urandom));
    push(8'($urandom));
    run_frame(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
